booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Parametrised sequential radix-2 Booth multiplier: WIDTH x WIDTH two's-complement operands, 2*WIDTH-bit product.
//  Replaces fixed-width start/busy multiplier with valid/ready handshakes on input and output.
//  Corrects most-negative-multiplicand overflow with a WIDTH+1-bit accumulator.
//  Sits as a datapath slave under the BIST controller / pattern generator; one operation in flight.
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range 2..32; product width 2*WIDTH
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous reset, active-high
//  in_valid     in   1          operands valid
//  in_ready     out  1          block can accept operands (high only in IDLE)
//  mc           in   WIDTH      multiplicand, captured on accept
//  mp           in   WIDTH      multiplier, captured on accept
//  is_unsigned  in   1          only with BOOTH_UNSIGNED_EN: treat mc/mp as unsigned; captured on accept
//  out_valid    out  1          prod valid; held until out_ready
//  out_ready    in   1          consumer accepts prod
//  prod         out  2*WIDTH    product {A[WIDTH-1:0], Q}
//  busy         out  1          high in RUN or DONE (legacy status)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, A=0, Q=0, M=0, Q_1=0, count=0. in_ready=1, out_valid=0, busy=0, prod=0.
//  - Reset overrides everything, including mid-RUN and DONE; the in-flight result is discarded and no out_valid is produced.
//  - States:
//    - IDLE: accept when in_valid&&in_ready at an edge.
//      Load M=sign-extended mc (WIDTH+1 bits), Q=mp, A=0, Q_1=0, count=0. Go to RUN.
//    - RUN: one Booth iteration per clock.
//      {Q[0],Q_1} = 01 -> A+=M; 10 -> A-=M; 00/11 -> no add.
//      Then arithmetic shift right {A,Q,Q_1} by 1, replicating A[WIDTH] (WIDTH+1-bit A; no overflow).
//      count++. After the N-th iteration go to DONE. N=WIDTH (signed).
//    - DONE: out_valid=1, prod stable. On out_ready at an edge go to IDLE.
//  - Latency: accept at edge E0; iterations at E1..EN. out_valid is high from the cycle after EN.
//    Earliest result consumption is at edge EN+1; next accept is at EN+2 at the earliest.
//  - in_ready=0 during RUN/DONE; in_valid there is ignored (operand changes have no effect after capture).
//  - out_ready while not DONE: ignored. prod holds the last result in IDLE until the next accept.
//  - Subtraction is A + ~M + 1 via the addsub sub-module with cin=1.
//  - Corner: mc=mp=-2^(WIDTH-1) gives +2^(2*WIDTH-2), exact; no saturation needed.
// CONFIGURATION
//  BOOTH_UNSIGNED_EN defined:
//    - port is_unsigned exists.
//    - If captured 1: M and Q are zero-extended to WIDTH+1 bits and N=WIDTH+1 iterations run.
//    - prod = low 2*WIDTH bits of the result; latency grows by 1.
//  BOOTH_UNSIGNED_EN undefined:
//    - port absent; all operations are signed; N=WIDTH.
//  count width = $clog2(WIDTH+2) in both builds.
// STRUCTURE
//  Package booth_pkg:
//    - state enum typedef {IDLE, RUN, DONE} (2 bits).
//    - Booth op encoding constants (NOP/ADD/SUB).
//  Sub-module booth_addsub #(W=WIDTH+1): out = a + (sub ? ~b : b) + sub.
//    Single instance, operation selected from {Q[0],Q_1}.
//  Top: FSM, operand/shift registers, iteration counter, handshake logic.
// TESTING (WIDTH=8 unless noted)
//  1. mc=7, mp=-3 (8'hFD), out_ready=1 -> out_valid 8 cycles after accept; prod=16'hFFEB; in_ready back high next cycle.
//  2. mc=-128, mp=-128 -> prod=16'h4000. mc=-128, mp=127 -> prod=16'hC080. mc=0, mp=8'h5A -> prod=16'h0000.
//  3. Backpressure: out_ready=0 for 5 cycles after out_valid -> prod and out_valid stable.
//     in_valid with new operands is not accepted; the result is consumed on the first out_ready.
//  4. Reset mid-op: rst=1 at iteration 3 -> next cycle in_ready=1, out_valid=0, prod=0.
//     A following 3*4 yields 16'h000C.
//  5. BOOTH_UNSIGNED_EN, is_unsigned=1: 255*255 -> prod=16'hFE01 after 9 cycles.
//     is_unsigned=0 with the same operands (-1*-1) -> 16'h0001 after 8 cycles.
//  6. Random sweep: WIDTH=4 exhaustive (256 pairs) and WIDTH=16 (10k random) vs a behavioural signed multiply.
//     Random in_valid/out_ready throttling; a scoreboard checks every handshake.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and Booth recoding of {Q[0],Q_1}.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } booth_op_t;

    // Radix-2 recoding: 01 adds M, 10 subtracts M, 00/11 leave A untouched.
    function automatic booth_op_t booth_op(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result handshake bundle for booth_mult_seq; is_unsigned exists only with BOOTH_UNSIGNED_EN.
interface booth_mult_seq_if #(parameter int WIDTH = 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     mc;
    logic [WIDTH-1:0]     mp;
`ifdef BOOTH_UNSIGNED_EN
    logic                 is_unsigned;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   prod;
    logic                 busy;

    modport master (
        output in_valid, mc, mp, out_ready,
`ifdef BOOTH_UNSIGNED_EN
        output is_unsigned,
`endif
        input  in_ready, out_valid, prod, busy
    );

    modport slave (
        input  in_valid, mc, mp, out_ready,
`ifdef BOOTH_UNSIGNED_EN
        input  is_unsigned,
`endif
        output in_ready, out_valid, prod, busy
    );

endinterface

// File: rtl/booth_addsub.sv
// Accumulator adder/subtractor: sum = a + (sub ? ~b : b) + sub, i.e. two's-complement subtract via carry-in.
module booth_addsub #(
    parameter int W = 9
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub,
    output logic signed [W-1:0] sum
);

    logic signed [W-1:0] b_eff;
    logic signed [W-1:0] cin;

    assign b_eff = sub ? ~b : b;
    assign cin   = $signed({{(W-1){1'b0}}, sub});
    assign sum   = a + b_eff + cin;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes and a WIDTH+1-bit accumulator.
// Define BOOTH_UNSIGNED_EN to add the is_unsigned operand mode (one extra iteration).
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    booth_mult_seq_if.slave bus
);

    localparam int AW = WIDTH + 1;
`ifdef BOOTH_UNSIGNED_EN
    localparam int QW = WIDTH + 1;
`else
    localparam int QW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);

    state_t                state;
    logic signed [AW-1:0]  a;
    logic signed [AW-1:0]  m;
    logic        [QW-1:0]  q;
    logic                  q_1;
    logic        [CW-1:0]  count;
    logic        [CW-1:0]  last;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  busy_r;
    booth_op_t             op;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  a_next;
    logic                  mc_ext;
    logic                  mp_ext;

    assign op     = booth_op(q[0], q_1);
    assign a_next = (op == OP_NOP) ? a : sum;

    booth_addsub #(.W(AW)) u_addsub (
        .a   (a),
        .b   (m),
        .sub (op == OP_SUB),
        .sum (sum)
    );

`ifdef BOOTH_UNSIGNED_EN
    logic uns;

    // Unsigned operands are zero-extended so the extra Booth step sees a positive multiplier.
    assign mc_ext    = bus.is_unsigned ? 1'b0 : bus.mc[WIDTH-1];
    assign mp_ext    = bus.is_unsigned ? 1'b0 : bus.mp[WIDTH-1];
    assign last      = uns ? CW'(WIDTH) : CW'(WIDTH - 1);
    // Signed runs shift WIDTH times, leaving the unused extension bit of Q at Q[0].
    assign bus.prod  = uns ? {a[WIDTH-2:0], q} : {a[WIDTH-1:0], q[QW-1:1]};
`else
    assign mc_ext    = bus.mc[WIDTH-1];
    assign mp_ext    = bus.mp[WIDTH-1];
    assign last      = CW'(WIDTH - 1);
    assign bus.prod  = {a[WIDTH-1:0], q};
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            q_1         <= 1'b0;
            count       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
            uns         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        m          <= $signed({mc_ext, bus.mc});
`ifdef BOOTH_UNSIGNED_EN
                        q          <= {mp_ext, bus.mp};
                        uns        <= bus.is_unsigned;
`else
                        q          <= bus.mp;
`endif
                        a          <= '0;
                        q_1        <= 1'b0;
                        count      <= '0;
                        state      <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    // Arithmetic shift of {A,Q,Q_1}; the extra accumulator bit absorbs -M overflow.
                    a     <= {a_next[AW-1], a_next[AW-1:1]};
                    q     <= {a_next[0], q[QW-1:1]};
                    q_1   <= q[0];
                    count <= count + 1'b1;
                    if (count == last) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Silence stage-3 style lint on the mp sign bit when only the unsigned build consumes it.
    logic unused_ok;
    assign unused_ok = mp_ext;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDTH=8): directed literals plus a throttled random sweep vs a behavioural model.
module tb_booth_mult_seq;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bit uflag;
`ifdef BOOTH_UNSIGNED_EN
    assign bus.is_unsigned = uflag;
`endif

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input bit u);
        logic signed [2*W+1:0] sx, sy, p;
        sx = u ? $signed({{(W+2){1'b0}}, x}) : $signed({{(W+2){x[W-1]}}, x});
        sy = u ? $signed({{(W+2){1'b0}}, y}) : $signed({{(W+2){y[W-1]}}, y});
        p  = sx * sy;
        return p[2*W-1:0];
    endfunction

    function automatic int n_iter(input bit u);
`ifdef BOOTH_UNSIGNED_EN
        return u ? W + 1 : W;
`else
        return u ? W : W;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: operation phase, remaining iterations and the expected product.
    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;
    int             ph = P_IDLE;
    int             left = 0;
    bit             armed = 1'b0;
    logic [2*W-1:0] pend = '0;
    logic [2*W-1:0] exp_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            ph       <= P_IDLE;
            exp_prod <= '0;
            armed    <= 1'b1;
        end else begin
            case (ph)
                P_IDLE: if (bus.in_valid) begin
                    ph   <= P_RUN;
                    left <= n_iter(uflag);
                    pend <= ref_mul(bus.mc, bus.mp, uflag);
                end
                P_RUN: begin
                    if (left == 1) begin
                        ph       <= P_DONE;
                        exp_prod <= pend;
                    end
                    left <= left - 1;
                end
                default: if (bus.out_ready) ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready", 32'(bus.in_ready), 32'(ph == P_IDLE));
            check("out_valid", 32'(bus.out_valid), 32'(ph == P_DONE));
            check("busy", 32'(bus.busy), 32'(ph != P_IDLE));
            if (ph != P_RUN) check("prod", 32'(bus.prod), 32'(exp_prod));
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit u);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.mc = x;
        bus.mp = y;
        uflag = u;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.mc = W'($urandom);
        bus.mp = W'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
            if (bus.out_valid) return;
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_directed(input logic [W-1:0] x, input logic [W-1:0] y, input bit u,
                                input logic [2*W-1:0] exp, input int exp_lat, input string nm);
        int lat;
        bus.out_ready = 1'b1;
        send(x, y, u);
        wait_valid(lat);
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_prod"}, 32'(bus.prod), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic finish_random();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.mc = W'($urandom);
            bus.mp = W'($urandom);
        end
        check("consume_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        rst = 1'b1;
        uflag = 1'b0;
        bus.in_valid = 1'b0;
        bus.mc = '0;
        bus.mp = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_prod", 32'(bus.prod), 32'd0);

        // Pin the reference model itself against hand-computed products.
        check("model_7x-3", 32'(ref_mul(8'd7, 8'hFD, 1'b0)), 32'h0000_FFEB);
        check("model_min_min", 32'(ref_mul(8'h80, 8'h80, 1'b0)), 32'h0000_4000);
        @(posedge clk);
        #1;

        run_directed(8'd7, 8'hFD, 1'b0, 16'hFFEB, 8, "t1_7x-3");
        @(negedge clk);
        check("t1_in_ready_back", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        run_directed(8'h80, 8'h80, 1'b0, 16'h4000, 8, "t2_min_min");
        run_directed(8'h80, 8'h7F, 1'b0, 16'hC080, 8, "t2_min_max");
        run_directed(8'h00, 8'h5A, 1'b0, 16'h0000, 8, "t2_zero");

        // Backpressure: result must hold and new operands must be refused.
        bus.out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0);
        wait_valid(lat);
        check("t3_prod", 32'(bus.prod), 32'h0000_03A8);
        bus.in_valid = 1'b1;
        bus.mc = 8'h55;
        bus.mp = 8'h66;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t3_hold_prod", 32'(bus.prod), 32'h0000_03A8);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_consumed", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation discards it.
        send(8'h55, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_in_ready", 32'(bus.in_ready), 32'd1);
        check("t4_out_valid", 32'(bus.out_valid), 32'd0);
        check("t4_prod", 32'(bus.prod), 32'd0);
        @(posedge clk);
        #1;
        run_directed(8'd3, 8'd4, 1'b0, 16'h000C, 8, "t4_3x4");

`ifdef BOOTH_UNSIGNED_EN
        run_directed(8'hFF, 8'hFF, 1'b1, 16'hFE01, 9, "t5_uns");
        run_directed(8'hFF, 8'hFF, 1'b0, 16'h0001, 8, "t5_sgn");
`endif

        // Throttled random sweep; the compare process checks every cycle.
        for (int n = 0; n < 500; n++) begin
            logic [W-1:0] x, y;
            bit u;
            x = pick();
            y = pick();
`ifdef BOOTH_UNSIGNED_EN
            u = 1'($urandom_range(0, 1));
`else
            u = 1'b0;
`endif
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            send(x, y, u);
            finish_random();
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
